// File: rtl/apb_cmd_master.sv
// APB4 master stage of the ICB-to-APB bridge: pops one command, runs one SETUP/ACCESS
// transfer, pushes one response. Define APB_TIMEOUT_EN to enable the ACCESS-phase watchdog.
module apb_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_WIDTH      = 1 + DATA_WIDTH/8 + ADDR_WIDTH + DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    rclk,
    input  logic                    rst,
    input  logic                    cmd_empty,
    output logic                    cmd_ren,
    input  logic [CMD_WIDTH-1:0]    cmd_data,
    input  logic                    rsp_full,
    output logic                    rsp_wen,
    output logic [DATA_WIDTH:0]     rsp_data,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr,
    output logic                    busy
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic                  cmd_write;
    logic [STRB_WIDTH-1:0] cmd_strb;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [DATA_WIDTH:0]   rsp_reg;
    logic                  timeout;

    // Command word layout is {write, strb, addr, wdata}, MSB first.
    assign cmd_write = cmd_data[CMD_WIDTH-1];
    assign cmd_strb  = cmd_data[ADDR_WIDTH+DATA_WIDTH +: STRB_WIDTH];
    assign cmd_addr  = cmd_data[DATA_WIDTH +: ADDR_WIDTH];
    assign cmd_wdata = cmd_data[DATA_WIDTH-1:0];

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] acc_cnt;

    // acc_cnt holds the number of ACCESS cycles already completed before this one.
    assign timeout = (state == ACCESS) && (acc_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge rclk) begin
        if (rst) begin
            acc_cnt <= '0;
        end else if (state == FETCH) begin
            acc_cnt <= '0;
        end else if (state == ACCESS && !timeout) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cmd_ren   = 1'b0;
        rsp_wen   = 1'b0;
        case (state)
            IDLE: begin
                if (!cmd_empty && !rst) begin
                    cmd_ren   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH:  state_nxt = SETUP;
            SETUP:  state_nxt = ACCESS;
            ACCESS: begin
                if (pready || timeout) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // A response still pending when reset arrives is dropped, never pushed.
                if (!rsp_full) begin
                    rsp_wen   = !rst;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            state   <= IDLE;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            pstrb   <= '0;
            rsp_reg <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
                pstrb  <= cmd_write ? cmd_strb : '0;
            end
            if (state == ACCESS) begin
                if (pready) begin
                    rsp_reg <= {pslverr, pwrite ? '0 : prdata};
                end else if (timeout) begin
                    rsp_reg <= {1'b1, {DATA_WIDTH{1'b0}}};
                end
            end
        end
    end

    assign psel     = (state == SETUP) || (state == ACCESS);
    assign penable  = (state == ACCESS);
    assign busy     = (state != IDLE);
    assign rsp_data = rsp_reg;

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Single-clock APB master stage of the ICB-to-APB bridge. It sits on the APB-clock side, directly downstream of the command async FIFO's read port and upstream of the response async FIFO's write port. It pops one command word, runs one APB4 transfer (SETUP/ACCESS), and pushes one response word (error flag plus read data) for every command, writes included.

## Interface
- `ADDR_WIDTH`, 32: APB address width.
- `DATA_WIDTH`, 32: APB data width. Must be a multiple of 8.
- `CMD_WIDTH`, 1+DATA_WIDTH/8+ADDR_WIDTH+DATA_WIDTH (69): command word width. Layout is {write, strb, addr, wdata}, MSB first.
- `TIMEOUT_CYCLES`, 256: ACCESS-phase watchdog limit. Used only with `APB_TIMEOUT_EN`.
- `rclk` input 1: the single clock (APB clock, same as the FIFO read/write clock on this side).
- `rst` input 1: reset, synchronous, active-high.
- `cmd_empty` input 1: command FIFO empty.
- `cmd_ren` output 1: command FIFO read enable, 1-cycle pulse.
- `cmd_data` input CMD_WIDTH: command FIFO read data. Valid the cycle after `cmd_ren`.
- `rsp_full` input 1: response FIFO full.
- `rsp_wen` output 1: response FIFO write enable, 1-cycle pulse.
- `rsp_data` output DATA_WIDTH+1: response word {pslverr, prdata}. prdata field is 0 for writes.
- `psel`, `penable`, `pwrite` output 1: APB control.
- `paddr` output ADDR_WIDTH, `pwdata` output DATA_WIDTH, `pstrb` output DATA_WIDTH/8: APB address, write data and strobes.
- `prdata` input DATA_WIDTH, `pready` input 1, `pslverr` input 1: APB completer response.
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states and transitions:
  - IDLE: `cmd_ren` = !`cmd_empty` (combinational, forced 0 while `rst`). If it is asserted, go to FETCH.
  - FETCH: register `cmd_data` into the command register, then go to SETUP.
  - SETUP: `psel`=1, `penable`=0; address, write, data and strobe come from the command register. Go to ACCESS.
  - ACCESS: `psel`=1, `penable`=1. Hold until `pready`=1. On that edge, capture {`pslverr`, read ? `prdata` : 0} into the response register and go to RESP.
  - RESP: `psel`=`penable`=0. If !`rsp_full`, pulse `rsp_wen` with `rsp_data` = response register and go to IDLE. Otherwise stay in RESP.
- `paddr`, `pwrite`, `pwdata` and `pstrb` are registered. They stay stable from SETUP through the last ACCESS cycle and keep their values after the transfer.
- `pstrb` is forced to 0 on reads; `pwdata` is a don't-care on reads.
- Exactly one push per pop. There is never more than one command in flight.
- Reset mid-transfer: on the next edge every register clears and the FSM returns to IDLE. `psel` drops even if ACCESS has not completed (accepted behaviour, because the whole bridge resets together). A pending response is discarded.
- Reset values: all outputs are 0 (`cmd_ren`, `rsp_wen`, `rsp_data`, `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `pstrb`, `busy`).

## Timing
- Cycle numbering, command present at cycle 0 with zero-wait completer: `cmd_ren` at 0, FETCH at 1, SETUP at 2, ACCESS at 3 (`pready`=1), `rsp_wen` at 4, IDLE at 5.
- Minimum 5 cycles per command. Back-to-back commands issue `cmd_ren` every 5 cycles.
- Each completer wait state (`pready`=0) adds 1 cycle. Each cycle with `rsp_full`=1 in RESP adds 1 cycle.
- `cmd_empty` and `rsp_full` are sampled only in IDLE and RESP respectively.

## Configuration
- `APB_TIMEOUT_EN` defined: an ACCESS-cycle counter runs, cleared on entry to SETUP.
  - If `pready` is still 0 after TIMEOUT_CYCLES ACCESS cycles, the transfer is terminated: response register = {1, 0}, then go to RESP.
  - `psel`/`penable` drop in RESP as normal.
- `APB_TIMEOUT_EN` undefined: no counter; ACCESS waits indefinitely.

## Test plan
- Reset: hold `rst` 3 cycles with `cmd_empty`=0 -> all outputs 0, no `cmd_ren` during reset, first `cmd_ren` on the first cycle after release.
- Write {1, 4'hF, 32'h1000_0004, 32'hDEAD_BEEF}, zero-wait completer -> SETUP at cycle 2, ACCESS at 3, `pstrb`=F; `rsp_wen` at cycle 4 with `rsp_data`={0, 32'h0}.
- Read from 32'h1000_0008 with 3 wait states, `prdata`=32'h1234_5678, `pslverr`=1 -> `penable` high 4 cycles, `pstrb`=0, `rsp_data`={1, 32'h1234_5678}.
- `rsp_full`=1 for 6 cycles at RESP -> `rsp_wen` stays 0, no new `cmd_ren`; push on the cycle `rsp_full` falls.
- `rst` asserted during ACCESS with `pready`=0 -> `psel`/`penable` drop at the next edge, no `rsp_wen`, a new fetch starts after release.
- With `APB_TIMEOUT_EN`, TIMEOUT_CYCLES=8, `pready` tied 0 -> ACCESS lasts 8 cycles, then `rsp_data`={1, 0}. Without the macro, still in ACCESS after 1000 cycles.
